text_char_fetch: RTL and testbench
==================================

Name: text_char_fetch

Overview:
- Alpha-mode video fetch stage sitting directly upstream of the character-generator ROM.
- Walks video RAM per scanline and forms the ROM address {char code, scanline-in-row}.
- Pulses the ROM clock enable and consumes the ROM's registered output.
- Serialises each byte MSB-first into a 1-bit pixel stream for the video mixer; one-character prefetch pipeline keyed off the pixel clock enable.

Parameters:
COLS, 32, characters per line (power of two)
ROWS, 16, character rows per frame
LINES_PER_ROW, 12, scanlines per character row (≤16)
ROM_AW, 10, ROM address width = 6 code bits + 4 scanline bits
VRAM_AW, 9, video RAM address width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ce  in  1  pixel clock enable; all state advances only when high
frame_start  in  1  pulse (qualified by ce): rewind to row 0, scanline 0
line_start  in  1  pulse (qualified by ce): begin fetch/display of one line
vram_addr  out  VRAM_AW  video RAM address
vram_data  in  8  video RAM data, valid one ce after vram_addr
rom_addr  out  ROM_AW  character ROM address
rom_ce  out  1  character ROM enable, one clock wide
rom_data  in  8  character ROM registered output
pixel  out  1  serial pixel
pixel_valid  out  1  high during the 256 (COLS*8) active pixels
attr  out  1  bit 7 of the character currently shifting out

Behaviour:
- Reset: vram_addr, rom_addr, rom_ce, pixel, pixel_valid, attr = 0; state IDLE; column, scanline and row counters = 0.
- ce low: every register holds. rom_ce is never high outside a ce cycle.
- States:
  - IDLE: line_start with row<ROWS -> PREFETCH. line_start with row==ROWS (frame done) is ignored.
  - PREFETCH: 8 ce slots; fetches column 0.
  - ACTIVE: COLS characters × 8 ce each.
- Slot counter 0..7 per character; actions on ce edges:
  - slot 0: vram_addr <= row*COLS + fetch_col.
  - slot 2: code <= vram_data; rom_addr <= {code[5:0], scanline[3:0]}.
  - slot 3: rom_ce high exactly this one clock.
  - slot 7: shifter <= rom_data XOR {8{code[6]}} (bit 6 = inverse); attr <= code[7]; fetch_col++.
  - Other ce: shifter shifts left; pixel <= shifter[7].
- Latency: line_start on ce n -> pixel_valid rises on the edge of ce n+9 -> high for exactly COLS*8 ce.
- During the last character no fetch is issued: vram_addr and rom_addr hold, no rom_ce.
- At the end of the last character: pixel_valid <= 0, pixel <= 0, -> IDLE.
- Line end: scanline++.
  - scanline==LINES_PER_ROW-1 -> scanline=0, row++.
  - row saturates at ROWS until frame_start.
- Simultaneous events and aborts:
  - frame_start with line_start in the same ce: frame_start applies first, then the line starts at row 0.
  - frame_start while PREFETCH/ACTIVE: abort; next edge IDLE, pixel_valid=0, counters 0.
  - line_start while PREFETCH/ACTIVE: ignored.
  - reset mid-line: same as reset.
- Width rules: row*COLS is a shift (COLS power of two), truncated to VRAM_AW. scanline uses its low 4 bits in rom_addr.

Decomposition:
- Shared package video_pkg holds the fetch_state_t enum (IDLE, PREFETCH, ACTIVE) and the constants COLS, ROWS, LINES_PER_ROW, PIXELS_PER_CHAR=8.
- One natural sub-module: pixel_shifter (8-bit load/shift register with invert, pixel and attr outputs).

Test Plan:
- Reset, then frame_start, then line_start with ce every clock; vram[0]=0x01, ROM[0x011]... ROM model at {0x01,0}=0xA5 -> pixel_valid rises 9 ce after line_start; first 8 pixels 1,0,1,0,0,1,0,1; rom_ce seen 31 times (not 32 — last char fetches nothing... first via prefetch: 32 total).
- vram[1]=0x41 (inverse), same ROM byte 0xA5 -> pixels 9-16 = 0,1,0,1,1,0,1,0; attr=0. vram[2]=0x81 -> attr=1 for pixels 17-24.
- ce every 3rd clock -> identical pixel sequence per ce; rom_ce width 1 clock; 256 valid ce per line.
- Run 12 lines -> 13th line reads vram_addr 32..63 and rom_addr scanline field 0. After 192 lines, line_start is ignored (pixel_valid stays 0) until frame_start.
- frame_start at pixel 100 -> pixel_valid 0 next clock; the following line_start fetches vram_addr 0, scanline 0.
- reset asserted mid-line for 1 clock -> all outputs 0 next clock; no rom_ce until the next line_start.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and types for the alpha-mode character fetch path.
// Geometry is fixed here so the fetch stage and its neighbours agree on it.
package video_pkg;

    localparam int COLS            = 32;
    localparam int ROWS            = 16;
    localparam int LINES_PER_ROW   = 12;
    localparam int PIXELS_PER_CHAR = 8;
    localparam int ROM_AW          = 10;
    localparam int VRAM_AW         = 9;

    localparam int COL_SHIFT = $clog2(COLS);
    localparam int COL_W     = COL_SHIFT + 1;
    localparam int ROW_W     = $clog2(ROWS + 1);
    localparam int SCAN_W    = 4;
    localparam int SLOT_W    = $clog2(PIXELS_PER_CHAR);

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        ACTIVE
    } fetch_state_t;

    typedef logic [SLOT_W-1:0] slot_t;

    // Fixed positions of the fetch actions inside each 8-slot character period.
    localparam slot_t SLOT_ADDR = slot_t'(0);
    localparam slot_t SLOT_CODE = slot_t'(2);
    localparam slot_t SLOT_ROM  = slot_t'(3);
    localparam slot_t SLOT_LOAD = slot_t'(PIXELS_PER_CHAR - 1);

    function automatic logic [VRAM_AW-1:0] vram_line_base(input logic [ROW_W-1:0] row);
        return VRAM_AW'(row) << COL_SHIFT;
    endfunction

endpackage

// File: rtl/pixel_shifter.sv
// 8-bit load/shift serialiser: emits glyph rows MSB-first with the attribute
// bit kept aligned to the character whose pixels are on the output.
module pixel_shifter (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] data_i,
    input  logic       invert_i,
    input  logic       attr_i,
    output logic       pixel_o,
    output logic       attr_o
);

    logic [7:0] shift_q;
    logic       attr_next_q;
    logic       pixel_q;
    logic       attr_q;

    always_ff @(posedge clock_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge value of its neighbours.
        if (reset_i || clear_i) begin
            shift_q     <= '0;
            attr_next_q <= 1'b0;
            pixel_q     <= 1'b0;
            attr_q      <= 1'b0;
        end else begin
            // A load may coincide with the last bit of the previous character.
            if (shift_i) begin
                pixel_q <= shift_q[7];
                attr_q  <= attr_next_q;
            end
            if (load_i) begin
                shift_q     <= data_i ^ {8{invert_i}};
                attr_next_q <= attr_i;
            end else if (shift_i) begin
                shift_q <= {shift_q[6:0], 1'b0};
            end
        end
    end

    assign pixel_o = pixel_q;
    assign attr_o  = attr_q;

endmodule

// File: rtl/text_char_fetch.sv
// Alpha-mode fetch stage: walks video RAM per scanline, addresses the character
// ROM and feeds a one-character-ahead pixel serialiser.
module text_char_fetch
    import video_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               ce,
    input  logic               frame_start,
    input  logic               line_start,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_data,
    output logic [ROM_AW-1:0]  rom_addr,
    output logic               rom_ce,
    input  logic [7:0]         rom_data,
    output logic               pixel,
    output logic               pixel_valid,
    output logic               attr
);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(COLS);
    localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(ROWS);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(LINES_PER_ROW - 1);

    fetch_state_t        state_q;
    slot_t               slot_q;
    logic [COL_W-1:0]    fetch_col_q;
    logic [COL_W-1:0]    disp_col_q;
    logic [ROW_W-1:0]    row_q;
    logic [SCAN_W-1:0]   scan_q;
    logic [1:0]          ctl_q;
    logic [VRAM_AW-1:0]  vram_addr_q;
    logic [ROM_AW-1:0]   rom_addr_q;
    logic                pixel_valid_q;

    logic [ROW_W-1:0]    row_d;
    logic [SCAN_W-1:0]   scan_d;
    logic [VRAM_AW-1:0]  vram_addr_d;

    logic                line_done;
    logic                last_char;
    logic                fetch_en;
    logic                shift_clear;
    logic                shift_load;
    logic                shift_out;

    // The ce after the last character's final pixel closes the line.
    assign line_done = (state_q == ACTIVE) && (disp_col_q == COL_END);
    assign last_char = (state_q == ACTIVE) && (disp_col_q == COL_LAST);
    assign fetch_en  = (state_q == PREFETCH) ||
                       ((state_q == ACTIVE) && !last_char && !line_done);

    assign vram_addr_d = vram_line_base(row_q) + VRAM_AW'(fetch_col_q);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block can infer a latch.
        scan_d = scan_q + 1'b1;
        row_d  = row_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            if (row_q != ROW_END) begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            fetch_col_q   <= '0;
            disp_col_q    <= '0;
            row_q         <= '0;
            scan_q        <= '0;
            ctl_q         <= '0;
            vram_addr_q   <= '0;
            rom_addr_q    <= '0;
            pixel_valid_q <= 1'b0;
        end else if (ce) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        row_q  <= '0;
                        scan_q <= '0;
                    end
                    // A rewind in the same ce re-enables a finished frame.
                    if (line_start && (frame_start || row_q != ROW_END)) begin
                        state_q     <= PREFETCH;
                        slot_q      <= '0;
                        fetch_col_q <= '0;
                        disp_col_q  <= '0;
                    end
                end
                PREFETCH, ACTIVE: begin
                    if (frame_start) begin
                        state_q       <= IDLE;
                        slot_q        <= '0;
                        fetch_col_q   <= '0;
                        disp_col_q    <= '0;
                        row_q         <= '0;
                        scan_q        <= '0;
                        pixel_valid_q <= 1'b0;
                    end else begin
                        if (fetch_en) begin
                            case (slot_q)
                                SLOT_ADDR: vram_addr_q <= vram_addr_d;
                                SLOT_CODE: begin
                                    ctl_q      <= vram_data[7:6];
                                    rom_addr_q <= {vram_data[5:0], scan_q};
                                end
                                SLOT_LOAD: fetch_col_q <= fetch_col_q + 1'b1;
                                default: ;
                            endcase
                        end
                        slot_q <= slot_q + 1'b1;

                        if (state_q == PREFETCH) begin
                            if (slot_q == SLOT_LOAD) begin
                                state_q <= ACTIVE;
                            end
                        end else if (line_done) begin
                            state_q       <= IDLE;
                            slot_q        <= '0;
                            pixel_valid_q <= 1'b0;
                            scan_q        <= scan_d;
                            row_q         <= row_d;
                        end else begin
                            pixel_valid_q <= 1'b1;
                            if (slot_q == SLOT_LOAD) begin
                                disp_col_q <= disp_col_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Shifter controls; clear wins over load/shift inside the shifter.
    assign shift_clear = ce && ((frame_start && state_q != IDLE) || line_done);
    assign shift_load  = ce && !frame_start && fetch_en && (slot_q == SLOT_LOAD);
    assign shift_out   = ce && !frame_start && (state_q == ACTIVE) && !line_done;

    pixel_shifter u_shifter (
        .clock_i  (clock),
        .reset_i  (reset),
        .clear_i  (shift_clear),
        .load_i   (shift_load),
        .shift_i  (shift_out),
        .data_i   (rom_data),
        .invert_i (ctl_q[0]),
        .attr_i   (ctl_q[1]),
        .pixel_o  (pixel),
        .attr_o   (attr)
    );

    // Gated by ce so the ROM strobe lasts exactly one clock at any ce rate.
    assign rom_ce = ce && !reset && !frame_start && fetch_en && (slot_q == SLOT_ROM);

    assign vram_addr   = vram_addr_q;
    assign rom_addr    = rom_addr_q;
    assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_text_char_fetch.sv
// Directed bench for text_char_fetch with behavioural video RAM and char ROM;
// expected pixels come from the bench's own glyph model.
module tb_text_char_fetch;
    import video_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               ce;
    logic               frame_start;
    logic               line_start;
    logic [VRAM_AW-1:0] vram_addr;
    logic [7:0]         vram_data;
    logic [ROM_AW-1:0]  rom_addr;
    logic               rom_ce;
    logic [7:0]         rom_data;
    logic               pixel;
    logic               pixel_valid;
    logic               attr;

    logic [7:0] vram_mem [0:(1<<VRAM_AW)-1];
    logic [7:0] rom_mem  [0:(1<<ROM_AW)-1];

    int checks = 0;
    int errors = 0;
    int ce_div = 1;
    int rom_ce_total = 0;
    int rom_ce_bad = 0;

    int r_rise, r_nvalid, r_pix_err, r_attr_err, r_sl_bad, r_rom_ce, r_vmin, r_vmax;
    logic pix_cap  [0:255];
    logic attr_cap [0:255];

    always #5 clock = ~clock;

    text_char_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .ce          (ce),
        .frame_start (frame_start),
        .line_start  (line_start),
        .vram_addr   (vram_addr),
        .vram_data   (vram_data),
        .rom_addr    (rom_addr),
        .rom_ce      (rom_ce),
        .rom_data    (rom_data),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .attr        (attr)
    );

    always @(posedge clock) begin
        if (ce) vram_data <= vram_mem[vram_addr];
        if (rom_ce) begin
            rom_data <= rom_mem[rom_addr];
            rom_ce_total++;
            if (!ce) rom_ce_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_code(input int row, input int p);
        return vram_mem[(row * COLS + p / 8) % (1 << VRAM_AW)];
    endfunction

    function automatic logic exp_pixel(input int row, input int sl, input int p);
        logic [7:0] code;
        logic [7:0] b;
        logic [ROM_AW-1:0] a;
        code = exp_code(row, p);
        a = {code[5:0], 4'(sl)};
        b = rom_mem[a] ^ {8{code[6]}};
        return b[7 - (p % 8)];
    endfunction

    function automatic logic [7:0] pack_cap(input int base, input bit use_attr);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[7-i] = use_attr ? attr_cap[base+i] : pix_cap[base+i];
        return v;
    endfunction

    function automatic int line_bad();
        return r_pix_err + r_attr_err + r_sl_bad + int'(r_rise != 9) +
               int'(r_nvalid != 256) + int'(r_rom_ce != 32);
    endfunction

    // One ce-qualified cycle (preceded by ce_div-1 idle clocks); returns at the next negedge.
    task automatic step(input logic fs, input logic ls);
        for (int i = 1; i < ce_div; i++) begin
            ce = 1'b0; frame_start = 1'b0; line_start = 1'b0;
            @(negedge clock);
        end
        ce = 1'b1; frame_start = fs; line_start = ls;
        @(negedge clock);
        ce = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    endtask

    task automatic run_line(input int row, input int sl);
        int k0;
        bit rose;
        int p;
        k0 = rom_ce_total; rose = 1'b0; p = 0;
        r_rise = -1; r_nvalid = 0; r_pix_err = 0; r_attr_err = 0; r_sl_bad = 0;
        r_vmin = 1 << VRAM_AW; r_vmax = -1;
        step(1'b0, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            step(1'b0, 1'b0);
            if (int'(vram_addr) < r_vmin) r_vmin = int'(vram_addr);
            if (int'(vram_addr) > r_vmax) r_vmax = int'(vram_addr);
            if (k >= 3 && int'(rom_addr[3:0]) != sl) r_sl_bad++;
            if (pixel_valid === 1'b1) begin
                if (!rose) r_rise = k;
                rose = 1'b1;
                if (p < 256) begin
                    pix_cap[p]  = pixel;
                    attr_cap[p] = attr;
                    if (pixel !== exp_pixel(row, sl, p)) r_pix_err++;
                    if (attr !== exp_code(row, p)[7]) r_attr_err++;
                end
                p++;
                r_nvalid++;
            end else if (rose) begin
                break;
            end
        end
        r_rom_ce = rom_ce_total - k0;
    endtask

    initial begin
        int bad;
        int npix;
        int k0;

        for (int i = 0; i < (1 << VRAM_AW); i++) vram_mem[i] = 8'(i * 29 + 5);
        vram_mem[0] = 8'h01;
        vram_mem[1] = 8'h41;
        vram_mem[2] = 8'h81;
        for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 8'(i * 7 + 3);
        rom_mem[10'h010] = 8'hA5;
        vram_data = '0;
        rom_data  = '0;

        reset = 1'b1; ce = 1'b1; frame_start = 1'b0; line_start = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'({vram_addr, rom_addr, rom_ce, pixel, pixel_valid, attr}), 0);
        reset = 1'b0; ce = 1'b0;
        @(negedge clock);

        // Line 1: row 0, scanline 0, ce every clock.
        step(1'b1, 1'b0);
        run_line(0, 0);
        check("l1_rise_ce", r_rise, 9);
        check("l1_valid_count", r_nvalid, 256);
        check("l1_char0_pixels", 32'(pack_cap(0, 1'b0)), 32'h0A5);
        check("l1_char1_inverse", 32'(pack_cap(8, 1'b0)), 32'h05A);
        check("l1_char2_pixels", 32'(pack_cap(16, 1'b0)), 32'h0A5);
        check("l1_char1_attr", 32'(pack_cap(8, 1'b1)), 32'h000);
        check("l1_char2_attr", 32'(pack_cap(16, 1'b1)), 32'h0FF);
        check("l1_pixel_errs", r_pix_err, 0);
        check("l1_attr_errs", r_attr_err, 0);
        check("l1_rom_ce_count", r_rom_ce, 32);
        check("l1_vram_min", r_vmin, 0);
        check("l1_vram_max", r_vmax, 31);

        // Line 2 with ce every third clock.
        ce_div = 3;
        run_line(0, 1);
        check("l2_div3_rise_ce", r_rise, 9);
        check("l2_div3_valid_count", r_nvalid, 256);
        check("l2_div3_pixel_errs", r_pix_err, 0);
        check("l2_div3_rom_ce_count", r_rom_ce, 32);
        check("rom_ce_outside_ce", rom_ce_bad, 0);
        ce_div = 1;

        bad = 0;
        for (int l = 3; l <= 12; l++) begin
            run_line((l - 1) / 12, (l - 1) % 12);
            bad += line_bad();
        end
        check("lines_3_12", bad, 0);

        run_line(1, 0);
        check("l13_vram_min", r_vmin, 32);
        check("l13_vram_max", r_vmax, 63);
        check("l13_scanline_field", r_sl_bad, 0);
        check("l13_pixel_errs", r_pix_err, 0);

        bad = 0;
        for (int l = 14; l <= 192; l++) begin
            run_line((l - 1) / 12, (l - 1) % 12);
            bad += line_bad();
        end
        check("lines_14_192", bad, 0);

        run_line(ROWS, 0);
        check("frame_done_no_valid", r_nvalid, 0);
        check("frame_done_no_rom_ce", r_rom_ce, 0);

        // Abort mid-line with frame_start.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        npix = 0;
        for (int k = 0; k < 200 && npix < 100; k++) begin
            step(1'b0, 1'b0);
            if (pixel_valid === 1'b1) npix++;
        end
        check("abort_reached_px100", npix, 100);
        step(1'b1, 1'b0);
        check("abort_valid_low", 32'(pixel_valid), 0);
        check("abort_pixel_low", 32'(pixel), 0);
        run_line(0, 0);
        check("abort_next_vram_min", r_vmin, 0);
        check("abort_next_vram_max", r_vmax, 31);
        check("abort_next_scanline", r_sl_bad, 0);
        check("abort_next_pixel_errs", r_pix_err, 0);

        // One-clock reset in the middle of a line.
        step(1'b0, 1'b1);
        repeat (50) step(1'b0, 1'b0);
        reset = 1'b1; ce = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midline_reset_outputs", 32'({vram_addr, rom_addr, rom_ce, pixel, pixel_valid, attr}), 0);
        ce = 1'b0;
        k0 = rom_ce_total;
        repeat (40) step(1'b0, 1'b0);
        check("post_reset_no_rom_ce", rom_ce_total - k0, 0);
        run_line(0, 0);
        check("post_reset_rise_ce", r_rise, 9);
        check("post_reset_pixel_errs", r_pix_err, 0);
        check("rom_ce_outside_ce_final", rom_ce_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
